nd_func_eval: RTL and testbench

//  Parametrised successor of the 4-input function core: evaluates z = sum_i (x_i - t_i)^2

---
 rtl/nd_func_pkg.sv | 24 ++
 rtl/nd_sq_term.sv | 37 +++
 rtl/nd_func_eval.sv | 157 +++++++++++++++
 tb/tb_nd_func_eval.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nd_func_pkg.sv
// nd_func_pkg
// Shared definitions for the N-channel squared-distance evaluator:
//   state_t    FSM state encoding {IDLE, CALC, DONE}
//   acc_max    largest positive value of a signed accumulator of a given width
//   idx_width  width of the channel index counter for a given channel count
// Optional feature macro used by the files importing this package: GRAD_OUT_EN
package nd_func_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic longint acc_max(input int acc_w);
        return (longint'(1) << (acc_w - 1)) - longint'(1);
    endfunction

    // A single channel still needs a one-bit index so the counter exists.
    function automatic int idx_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/nd_sq_term.sv
// nd_sq_term
// Combinational per-channel term: d = x - t (one bit wider than the inputs),
// p = d*d, term = p >>> FRAC_W (truncating). Shared by all channels.
// Ports:
//   x, t   in   DATA_W        signed fixed-point operand and target
//   diff   out  DATA_W+1      x - t (present only with GRAD_OUT_EN)
//   term   out  2*DATA_W+2    squared difference rescaled to FRAC_W fractional bits
// Configuration macro: GRAD_OUT_EN exposes the difference for the gradient output.
module nd_sq_term #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   t,
`ifdef GRAD_OUT_EN
    output logic [DATA_W:0]     diff,
`endif
    output logic [2*DATA_W+1:0] term
);

    logic signed [DATA_W:0]     d;
    logic signed [2*DATA_W+1:0] d_ext;
    logic signed [2*DATA_W+1:0] p;

    // Square is always non-negative, so the arithmetic shift is a plain truncation.
    always_comb begin
        d     = $signed({x[DATA_W-1], x}) - $signed({t[DATA_W-1], t});
        d_ext = {{(DATA_W + 1){d[DATA_W]}}, d};
        p     = d_ext * d_ext;
        term  = p >>> FRAC_W;
    end

`ifdef GRAD_OUT_EN
    assign diff = d;
`endif

endmodule

// File: rtl/nd_func_eval.sv
// nd_func_eval
// Evaluates z = sum_i (x_i - t_i)^2 over N_CH signed fixed-point channels, one
// channel per clock through a single shared squarer, with saturating
// accumulation and a sticky overflow flag. Level handshake start_func/func_done.
// Ports:
//   clk         in   1               rising-edge clock
//   rst_n       in   1               synchronous active-low reset
//   start_func  in   1               run request, sampled only in IDLE
//   x_in        in   N_CH*DATA_W     operands, channel i = [i*DATA_W +: DATA_W]
//   t_in        in   N_CH*DATA_W     targets, same packing
//   z_out       out  ACC_W           result, valid while func_done=1
//   func_done   out  1               result valid, held until start_func low
//   overflow    out  1               result saturated, valid with func_done
//   busy        out  1               high in CALC and DONE
//   grad_out    out  N_CH*(DATA_W+2) per-channel 2*(x_i - t_i) (GRAD_OUT_EN only)
// Configuration macro: GRAD_OUT_EN adds grad_out and its registers.
module nd_func_eval
    import nd_func_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_func,
    input  logic [N_CH*DATA_W-1:0]     x_in,
    input  logic [N_CH*DATA_W-1:0]     t_in,
    output logic [ACC_W-1:0]           z_out,
    output logic                       func_done,
    output logic                       overflow,
`ifdef GRAD_OUT_EN
    output logic [N_CH*(DATA_W+2)-1:0] grad_out,
`endif
    output logic                       busy
);

    localparam int IDX_W  = idx_width(N_CH);
    localparam int TERM_W = 2 * DATA_W + 2;
    localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(acc_max(ACC_W));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [N_CH*DATA_W-1:0] x_reg;
    logic [N_CH*DATA_W-1:0] t_reg;
    logic [ACC_W-1:0]       acc;
    logic                   ovf;
    logic [DATA_W-1:0]      x_sel;
    logic [DATA_W-1:0]      t_sel;
    logic [TERM_W-1:0]      term;
    logic [SUM_W-1:0]       sum;
    logic                   sat;
`ifdef GRAD_OUT_EN
    logic [DATA_W:0]              diff;
    logic [N_CH*(DATA_W+2)-1:0]   grad_reg;
`endif

    assign x_sel = x_reg[idx*DATA_W +: DATA_W];
    assign t_sel = t_reg[idx*DATA_W +: DATA_W];

    nd_sq_term #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sq_term (
        .x    (x_sel),
        .t    (t_sel),
`ifdef GRAD_OUT_EN
        .diff (diff),
`endif
        .term (term)
    );

    // acc and term are both non-negative, so an unsigned widened sum is exact.
    assign sum = SUM_W'(acc) + SUM_W'(term);
    assign sat = (sum > SUM_W'(ACC_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // DONE is left only after func_done has been shown for at least one cycle,
    // which yields the single-cycle pulse when start_func dropped during CALC.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start_func)              state_next = CALC;
            CALC:    if (idx == LAST_IDX)         state_next = DONE;
            DONE:    if (func_done && !start_func) state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            x_reg     <= '0;
            t_reg     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            z_out     <= '0;
            func_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    func_done <= 1'b0;
                    if (start_func) begin
                        x_reg <= x_in;
                        t_reg <= t_in;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    if (sat) begin
                        acc <= ACC_MAX;
                        ovf <= 1'b1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
                    idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end
                DONE: begin
                    if (func_done && !start_func) begin
                        func_done <= 1'b0;
                    end else begin
                        func_done <= 1'b1;
                        z_out     <= acc;
                        overflow  <= ovf;
                    end
                end
                default: func_done <= 1'b0;
            endcase
        end
    end

`ifdef GRAD_OUT_EN
    // Each lane is 2*(x-t): the difference shifted left by one, sign preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grad_reg <= '0;
        end else if (state == CALC) begin
            grad_reg[idx*(DATA_W+2) +: (DATA_W+2)] <= {diff, 1'b0};
        end
    end

    assign grad_out = grad_reg;
`endif

endmodule

// File: tb/tb_nd_func_eval.sv
// tb_nd_func_eval
// Scoreboard bench for nd_func_eval: two instances (ACC_W=32 and ACC_W=24) share
// stimulus; a reference model computes the expected sums from the arithmetic
// definition, a monitor compares on each rising func_done.
// Configuration macro: GRAD_OUT_EN also checks grad_out.
module tb_nd_func_eval;

    localparam int N_CH   = 4;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int GW     = N_CH * (DATA_W + 2);
    localparam longint MAX32 = 64'd2147483647;
    localparam longint MAX24 = 64'd8388607;

    typedef struct {
        longint         z32;
        longint         z24;
        bit             ovf32;
        bit             ovf24;
        logic [GW-1:0]  grad;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic                   start_func;
    logic [N_CH*DATA_W-1:0] x_in;
    logic [N_CH*DATA_W-1:0] t_in;
    logic [31:0]            z_out;
    logic                   func_done;
    logic                   overflow;
    logic                   busy;
    logic [23:0]            z_sat;
    logic                   done_sat;
    logic                   ovf_sat;
    logic                   busy_sat;
`ifdef GRAD_OUT_EN
    logic [GW-1:0]          grad_out;
    logic [GW-1:0]          grad_sat;
`endif

    int   assertions = 0;
    int   failures   = 0;
    exp_t exp_q[$];
    logic prev_done;

    nd_func_eval #(.N_CH(N_CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_func (start_func),
        .x_in       (x_in),
        .t_in       (t_in),
        .z_out      (z_out),
        .func_done  (func_done),
        .overflow   (overflow),
`ifdef GRAD_OUT_EN
        .grad_out   (grad_out),
`endif
        .busy       (busy)
    );

    nd_func_eval #(.N_CH(N_CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(24)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_func (start_func),
        .x_in       (x_in),
        .t_in       (t_in),
        .z_out      (z_sat),
        .func_done  (done_sat),
        .overflow   (ovf_sat),
`ifdef GRAD_OUT_EN
        .grad_out   (grad_sat),
`endif
        .busy       (busy_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum of floor((x-t)^2 / 2^FRAC_W), clamped to the positive range.
    function automatic exp_t model(input logic [N_CH*DATA_W-1:0] xs,
                                   input logic [N_CH*DATA_W-1:0] ts);
        exp_t   e;
        longint total;
        longint d;
        int     xv;
        int     tv;
        total  = 0;
        e.grad = '0;
        for (int i = 0; i < N_CH; i++) begin
            xv    = $signed(xs[i*DATA_W +: DATA_W]);
            tv    = $signed(ts[i*DATA_W +: DATA_W]);
            d     = longint'(xv) - longint'(tv);
            total = total + (d * d) / (longint'(1) << FRAC_W);
            e.grad[i*(DATA_W+2) +: (DATA_W+2)] = 18'(2 * d);
        end
        e.ovf32 = (total > MAX32);
        e.ovf24 = (total > MAX24);
        e.z32   = e.ovf32 ? MAX32 : total;
        e.z24   = e.ovf24 ? MAX24 : total;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // mode 0: keep start_func high for hold cycles past done, then drop.
    // mode 1: drop start_func right after it is accepted (single-cycle done pulse).
    task automatic applyStimulus(input logic [N_CH*DATA_W-1:0] xs,
                                 input logic [N_CH*DATA_W-1:0] ts,
                                 input int mode, input int hold);
        exp_t e;
        int   edges;
        bit   held_ok;
        e = model(xs, ts);
        @(negedge clk);
        x_in       = xs;
        t_in       = ts;
        start_func = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        checkOutput("busy_calc", {127'd0, busy}, 128'd1);
        edges = 0;
        while (!func_done && edges < 20) begin
            @(negedge clk);
            x_in = {$urandom, $urandom};
            t_in = {$urandom, $urandom};
            if (mode == 1) start_func = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", 128'(edges), 128'd5);
        if (mode == 1) begin
            @(posedge clk); #1;
            checkOutput("pulse_end", {127'd0, func_done}, 128'd0);
        end else begin
            held_ok = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!func_done) held_ok = 1'b0;
            end
            checkOutput("done_held", {127'd0, held_ok}, 128'd1);
            @(negedge clk);
            start_func = 1'b0;
            @(posedge clk); #1;
            checkOutput("done_drop", {127'd0, func_done}, 128'd0);
        end
        checkOutput("busy_idle", {127'd0, busy}, 128'd0);
        checkOutput("z_hold_idle", 128'(z_out), 128'(e.z32));
    endtask

    // Monitor: compare each presented result against the oldest expectation.
    initial begin
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (func_done && !prev_done) begin
                checkOutput("done_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("z32", 128'(z_out), 128'(e.z32));
                    checkOutput("ovf32", {127'd0, overflow}, 128'(e.ovf32));
                    checkOutput("done24", {127'd0, done_sat}, 128'd1);
                    checkOutput("z24", 128'(z_sat), 128'(e.z24));
                    checkOutput("ovf24", {127'd0, ovf_sat}, 128'(e.ovf24));
`ifdef GRAD_OUT_EN
                    checkOutput("grad", 128'(grad_out), 128'(e.grad));
`endif
                end
            end
            prev_done = func_done;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N_CH*DATA_W-1:0] xs;
        int wait_cnt;
        rst_n      = 1'b0;
        start_func = 1'b0;
        x_in       = '0;
        t_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_done", {127'd0, func_done}, 128'd0);
        checkOutput("rst_z", 128'(z_out), 128'd0);
        checkOutput("rst_busy", {127'd0, busy}, 128'd0);
        checkOutput("rst_ovf", {127'd0, overflow}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] unit operands");
        applyStimulus({N_CH{16'h0100}}, '0, 0, 3);
        checkOutput("t1_const", 128'(z_out), 128'h400);

        $display("[TB] sweep");
        for (int k = 1; k <= 10; k++) begin
            xs = {N_CH{16'(k * 16'h0040)}};
            applyStimulus(xs, '0, k % 2, 2);
            if (k == 1) checkOutput("t2_const", 128'(z_out), 128'h40);
        end

        $display("[TB] extreme operands");
        applyStimulus({N_CH{16'h8000}}, {N_CH{16'h7FFF}}, 0, 1);
        checkOutput("t3_ovf32", {127'd0, overflow}, 128'd0);
        checkOutput("t3_z24", 128'(z_sat), 128'h7FFFFF);
        checkOutput("t3_ovf24", {127'd0, ovf_sat}, 128'd1);

        $display("[TB] reset during CALC");
        @(negedge clk);
        x_in       = {N_CH{16'h0100}};
        t_in       = '0;
        start_func = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        start_func = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_done", {127'd0, func_done}, 128'd0);
        checkOutput("abort_z", 128'(z_out), 128'd0);
        checkOutput("abort_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("abort_quiet", {127'd0, func_done}, 128'd0);
        applyStimulus({N_CH{16'h0100}}, '0, 0, 0);

        $display("[TB] long hold and mid-CALC drop");
        applyStimulus({N_CH{16'h0300}}, {N_CH{16'hFF00}}, 0, 20);
        applyStimulus({N_CH{16'h0200}}, '0, 1, 0);

        $display("[TB] gradient pattern");
        applyStimulus({N_CH{16'h0180}}, {N_CH{16'h0100}}, 0, 1);
`ifdef GRAD_OUT_EN
        checkOutput("t6_grad", 128'(grad_out), 128'({N_CH{18'h00100}}));
`endif

        $display("[TB] random runs");
        for (int r = 0; r < 30; r++) begin
            xs = {$urandom, $urandom};
            if (r % 3 == 0) xs = xs & {N_CH{16'h03FF}};
            applyStimulus(xs, {$urandom, $urandom} & {N_CH{16'(r % 2 ? 16'hFFFF : 16'h03FF)}},
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 50) begin
            @(posedge clk);
            wait_cnt++;
        end
        checkOutput("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
